// File: rtl/long_divider_if.sv
// Operand/result bundle for the 7-bit / 4-bit CAS-array divider.
// Ports: D (dividend), M (divisor) toward the divider; Q, R and the two
// debug views (debug_cas_array_sum, debug_Q_wire) back from it.
interface long_divider_if;
  logic [6:0] D;
  logic [3:0] M;
  logic [3:0] Q;
  logic [3:0] R;
  logic [4:0] debug_cas_array_sum;
  logic [3:0] debug_Q_wire;

  // master: operand source / result consumer
  modport master (
    output D, M,
    input  Q, R, debug_cas_array_sum, debug_Q_wire
  );

  // slave: the divider itself
  modport slave (
    input  D, M,
    output Q, R, debug_cas_array_sum, debug_Q_wire
  );
endinterface

// File: rtl/long_divider.sv
// Unsigned 7-bit / 4-bit divider: 4-row non-restoring CAS array, registered outputs.
// Latency: 1 cycle; new operands accepted every cycle.
// Backpressure: none (no handshake, no busy state).
// Ports: clk, rst (synchronous, active-high); dif.slave carries D, M in and
// Q, R, debug_cas_array_sum, debug_Q_wire out.
module long_divider (
  input  logic            clk,
  input  logic            rst,
  long_divider_if.slave   dif
);

  // One CAS row: shift-in already applied by the caller. The sign of the
  // previous partial remainder (via its quotient bit) picks add or subtract.
  function automatic logic [4:0] cas_row(input logic [4:0] s,
                                         input logic [4:0] mz,
                                         input logic       q_prev);
    cas_row = q_prev ? (s - mz) : (s + mz);
  endfunction

  logic [4:0] mz;
  logic [4:0] p3, p2, p1, p0;
  logic [3:0] qw;
  logic [4:0] rc;
  logic       special;

  logic [3:0] q_d, r_d, qw_d;
  logic [4:0] sum_d;
  logic [3:0] q_q, r_q, qw_q;
  logic [4:0] sum_q;

  always_comb begin
    mz    = {1'b0, dif.M};
    p3    = {1'b0, dif.D[6:3]} - mz;
    qw[3] = ~p3[4];
    p2    = cas_row({p3[3:0], dif.D[2]}, mz, qw[3]);
    qw[2] = ~p2[4];
    p1    = cas_row({p2[3:0], dif.D[1]}, mz, qw[2]);
    qw[1] = ~p1[4];
    p0    = cas_row({p1[3:0], dif.D[0]}, mz, qw[1]);
    qw[0] = ~p0[4];

    // A negative final partial remainder needs one add-back of the divisor.
    rc = p0[4] ? (p0 + mz) : p0;

    // Quotient must fit in 4 bits: D < 16*M, compared at 8 bits.
    special = (dif.M == 4'd0) || ({1'b0, dif.D} >= {dif.M, 4'h0});

    q_d   = special ? 4'hF : qw;
    r_d   = special ? 4'hF : rc[3:0];
    qw_d  = qw;
    sum_d = p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= 4'd0;
      r_q   <= 4'd0;
      qw_q  <= 4'd0;
      sum_q <= 5'd0;
    end else begin
      q_q   <= q_d;
      r_q   <= r_d;
      qw_q  <= qw_d;
      sum_q <= sum_d;
    end
  end

  assign dif.Q                   = q_q;
  assign dif.R                   = r_q;
  assign dif.debug_Q_wire        = qw_q;
  assign dif.debug_cas_array_sum = sum_q;

endmodule

// File: tb/tb_long_divider.sv
module tb_long_divider;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic [4:0] sum;
    logic [3:0] qw;
    bit         chk_dbg;
    string      name;
  } exp_t;

  logic clk;
  logic rst;
  logic issue_vld;
  logic vld_q;

  long_divider_if dif ();

  long_divider u_dut (
    .clk (clk),
    .rst (rst),
    .dif (dif.slave)
  );

  exp_t sb_q[$];
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One result is due after every edge where the stimulus issued something.
  always @(posedge clk) vld_q <= issue_vld;

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (vld_q === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: result present but no expectation queued");
      end else begin
        exp_t e;
        bit   ok;
        e  = sb_q.pop_front();
        ok = (dif.Q === e.q) && (dif.R === e.r);
        if (e.chk_dbg)
          ok = ok && (dif.debug_cas_array_sum === e.sum) && (dif.debug_Q_wire === e.qw);
        total++;
        if (!ok) begin
          bad++;
          $display("FAIL %s: got Q=%b R=%b sum=%b qw=%b, want Q=%b R=%b sum=%b qw=%b (dbg checked=%0d)",
                   e.name, dif.Q, dif.R, dif.debug_cas_array_sum, dif.debug_Q_wire,
                   e.q, e.r, e.sum, e.qw, e.chk_dbg);
        end
      end
    end
  end

  // Drive one edge's worth of stimulus and queue the expected result.
  task automatic issue(input logic [6:0] d, input logic [3:0] m, input logic r_v,
                       input logic [3:0] q, input logic [3:0] r,
                       input logic [4:0] sum, input logic [3:0] qw,
                       input bit chk, input string name);
    exp_t e;
    @(negedge clk);
    dif.D     = d;
    dif.M     = m;
    rst       = r_v;
    issue_vld = 1'b1;
    e.q = q; e.r = r; e.sum = sum; e.qw = qw; e.chk_dbg = chk; e.name = name;
    sb_q.push_back(e);
  endtask

  initial begin
    int budget;
    int qe, re;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    issue_vld = 1'b0;
    dif.D     = 7'd0;
    dif.M     = 4'd0;
    vld_q     = 1'b0;

    // Reset for two edges with nonzero operands present: outputs must be 0.
    issue(7'd45, 4'd3, 1'b1, 4'd0, 4'd0, 5'd0, 4'd0, 1, "reset_edge1");
    issue(7'd45, 4'd3, 1'b1, 4'd0, 4'd0, 5'd0, 4'd0, 1, "reset_edge2");

    // Directed vectors with hand-worked array values.
    issue(7'd7,   4'd2, 1'b0, 4'b0011, 4'b0001, 5'b00001, 4'b0011, 1, "d7_m2");
    issue(7'd6,   4'd2, 1'b0, 4'b0011, 4'b0000, 5'b00000, 4'b0011, 1, "d6_m2");
    issue(7'd9,   4'd4, 1'b0, 4'b0010, 4'b0001, 5'b11101, 4'b0010, 1, "d9_m4");
    issue(7'd12,  4'd5, 1'b0, 4'b0010, 4'b0010, 5'b11101, 4'b0010, 1, "d12_m5");
    issue(7'd0,   4'd7, 1'b0, 4'b0000, 4'b0000, 5'b11001, 4'b0000, 1, "d0_m7");
    issue(7'd45,  4'd0, 1'b0, 4'b1111, 4'b1111, 5'b01101, 4'b1101, 1, "div_by_zero");
    issue(7'd127, 4'd1, 1'b0, 4'b1111, 4'b1111, 5'b10110, 4'b1000, 1, "overflow_127_1");
    issue(7'd119, 4'd8, 1'b0, 4'b1110, 4'b0111, 5'b11111, 4'b1110, 1, "d119_m8");
    // Boundary: D = 16*M - 1 fits, D = 16*M overflows.
    issue(7'd47,  4'd3, 1'b0, 4'b1111, 4'b0010, 5'd0, 4'd0, 0, "edge_47_3");
    issue(7'd48,  4'd3, 1'b0, 4'b1111, 4'b1111, 5'd0, 4'd0, 0, "edge_48_3");

    // Back-to-back with a reset slipped in between the 2nd and 3rd.
    issue(7'd7,   4'd2, 1'b0, 4'b0011, 4'b0001, 5'b00001, 4'b0011, 1, "b2b_7_2");
    issue(7'd6,   4'd2, 1'b0, 4'b0011, 4'b0000, 5'b00000, 4'b0011, 1, "b2b_6_2");
    issue(7'd9,   4'd4, 1'b1, 4'd0,    4'd0,    5'd0,     4'd0,    1, "b2b_reset");
    issue(7'd9,   4'd4, 1'b0, 4'b0010, 4'b0001, 5'b11101, 4'b0010, 1, "b2b_9_4");

    // Sweep every operand pair against an arithmetic reference.
    for (int m = 0; m < 16; m++) begin
      for (int d = 0; d < 128; d++) begin
        if (m == 0 || d >= 16 * m) begin
          qe = 15; re = 15;
        end else begin
          qe = d / m; re = d % m;
        end
        issue(d[6:0], m[3:0], 1'b0, qe[3:0], re[3:0], 5'd0, 4'd0, 0,
              $sformatf("sweep_d%0d_m%0d", d, m));
      end
    end

    @(negedge clk);
    issue_vld = 1'b0;

    // Drain the scoreboard, bounded.
    budget = 20;
    while (sb_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d expectations left, want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
